// File: rtl/mul_hilo_ctrl_if.sv
// rtl/mul_hilo_ctrl_if.sv - execute-side op request and writeback completion bundle for mul_hilo_ctrl
interface mul_hilo_ctrl_if;
   // op request from execute
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [31:0] in_a;
   logic [31:0] in_b;

   // completion toward writeback
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_wen;

   // execute/writeback side
   modport master (
      output in_valid,
      output in_op,
      output in_a,
      output in_b,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_wen,
      output out_ready
   );

   // controller side
   modport slave (
      input  in_valid,
      input  in_op,
      input  in_a,
      input  in_b,
      output in_ready,
      output out_valid,
      output out_data,
      output out_wen,
      input  out_ready
   );
endinterface

// File: rtl/mul_hilo_ctrl.sv
// rtl/mul_hilo_ctrl.sv - HI/LO owner and sequencer for the registered multiplier, incl. multiply-accumulate
module mul_hilo_ctrl (
   input  logic                 mul_clk,
   input  logic                 resetn,
   mul_hilo_ctrl_if.slave       bus,
   input  logic                 flush,
   output logic                 mul_signed,
   output logic [31:0]          mul_x,
   output logic [31:0]          mul_y,
   input  logic [63:0]          mul_result,
   output logic [31:0]          hi,
   output logic [31:0]          lo,
   output logic                 busy
);

   localparam logic [3:0] OP_MULT  = 4'd0;
   localparam logic [3:0] OP_MULTU = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd2;
   localparam logic [3:0] OP_MADD  = 4'd3;
   localparam logic [3:0] OP_MADDU = 4'd4;
   localparam logic [3:0] OP_MSUB  = 4'd5;
   localparam logic [3:0] OP_MSUBU = 4'd6;
   localparam logic [3:0] OP_MTHI  = 4'd7;
   localparam logic [3:0] OP_MTLO  = 4'd8;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_ACC  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      state;
   logic [3:0]  op_r;
   logic [31:0] hi_r;
   logic [31:0] lo_r;
   logic [63:0] prod_r;
   logic [31:0] out_data_r;
   logic        out_wen_r;

   logic        accept;
   logic        is_sub;
   logic [63:0] acc_next;

   // operands go straight to the multiplier so the product lands the cycle after accept
   assign mul_x = bus.in_a;
   assign mul_y = bus.in_b;

   // signedness follows the op being presented, not the latched one
   always_comb begin
      mul_signed = 1'b0;
      case (bus.in_op)
         OP_MULT, OP_MUL, OP_MADD, OP_MSUB: mul_signed = 1'b1;
         default:                           mul_signed = 1'b0;
      endcase
   end

   assign bus.in_ready  = (state == S_IDLE) & ~flush;
   assign accept        = bus.in_valid & bus.in_ready;
   assign bus.out_valid = (state == S_DONE);
   assign bus.out_data  = out_data_r;
   assign bus.out_wen   = out_wen_r;
   assign busy          = (state != S_IDLE);
   assign hi            = hi_r;
   assign lo            = lo_r;

   // 64-bit accumulate on {hi,lo}; carry/borrow crosses LO->HI and wraps modulo 2^64
   always_comb begin
      is_sub   = (op_r == OP_MSUB) || (op_r == OP_MSUBU);
      acc_next = is_sub ? ({hi_r, lo_r} - prod_r) : ({hi_r, lo_r} + prod_r);
   end

   // sequencing FSM; flush in MUL/ACC wins over the HI/LO commit of that edge
   always_ff @(posedge mul_clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         op_r       <= 4'd0;
         hi_r       <= 32'd0;
         lo_r       <= 32'd0;
         prod_r     <= 64'd0;
         out_data_r <= 32'd0;
         out_wen_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  op_r <= bus.in_op;
                  if (bus.in_op <= OP_MSUBU) begin
                     state <= S_MUL;
                  end else begin
                     // moves to HI/LO commit at the accept edge; illegal ops just complete
                     if (bus.in_op == OP_MTHI) begin
                        hi_r <= bus.in_a;
                     end else if (bus.in_op == OP_MTLO) begin
                        lo_r <= bus.in_a;
                     end
                     state <= S_DONE;
                  end
               end
            end
            S_MUL: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  case (op_r)
                     OP_MULT, OP_MULTU: begin
                        hi_r  <= mul_result[63:32];
                        lo_r  <= mul_result[31:0];
                        state <= S_DONE;
                     end
                     OP_MUL: begin
                        out_data_r <= mul_result[31:0];
                        out_wen_r  <= 1'b1;
                        state      <= S_DONE;
                     end
                     default: begin
                        prod_r <= mul_result;
                        state  <= S_ACC;
                     end
                  endcase
               end
            end
            S_ACC: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  hi_r  <= acc_next[63:32];
                  lo_r  <= acc_next[31:0];
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               if (flush || bus.out_ready) begin
                  state      <= S_IDLE;
                  out_data_r <= 32'd0;
                  out_wen_r  <= 1'b0;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb/tb_mul_hilo_ctrl.sv - scoreboard bench for mul_hilo_ctrl with a behavioural registered multiplier
module tb_mul_hilo_ctrl;

   logic        mul_clk = 1'b0;
   logic        resetn  = 1'b0;
   logic        flush   = 1'b0;
   logic        mul_signed;
   logic [31:0] mul_x;
   logic [31:0] mul_y;
   logic [63:0] mul_result;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        busy;

   int cyc    = 0;
   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] data;
      logic        wen;
      int          lat;
      int          acc_cyc;
   } exp_t;

   exp_t q[$];

   mul_hilo_ctrl_if bus ();

   mul_hilo_ctrl dut (
      .mul_clk    (mul_clk),
      .resetn     (resetn),
      .bus        (bus),
      .flush      (flush),
      .mul_signed (mul_signed),
      .mul_x      (mul_x),
      .mul_y      (mul_y),
      .mul_result (mul_result),
      .hi         (hi),
      .lo         (lo),
      .busy       (busy)
   );

   always #5 mul_clk = ~mul_clk;

   always @(posedge mul_clk) cyc <= cyc + 1;

   // external multiplier: product registered on every edge
   always @(posedge mul_clk) begin
      if (mul_signed)
         mul_result <= $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});
      else
         mul_result <= {32'd0, mul_x} * {32'd0, mul_y};
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic exp_sgn, input bit push,
                        input logic [31:0] e_hi, input logic [31:0] e_lo,
                        input logic [31:0] e_data, input logic e_wen, input int e_lat,
                        output int acc_cyc);
      int   guard;
      exp_t e;
      guard = 0;
      @(negedge mul_clk);
      bus.in_valid = 1'b1;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      #1;
      while (!bus.in_ready && guard < 50) begin
         @(negedge mul_clk);
         #1;
         guard++;
      end
      acc_cyc = cyc;
      if (!bus.in_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         chk("mul_signed", {63'd0, mul_signed}, {63'd0, exp_sgn});
         if (push) begin
            e.hi = e_hi; e.lo = e_lo; e.data = e_data; e.wen = e_wen;
            e.lat = e_lat; e.acc_cyc = cyc;
            q.push_back(e);
         end
      end
      @(negedge mul_clk);
      bus.in_valid = 1'b0;
   endtask

   // monitor: compares every cycle the DUT presents a completion, pops on handshake
   initial begin
      bit   seen;
      exp_t e;
      seen = 0;
      forever begin
         @(negedge mul_clk);
         #1;
         if (!resetn) begin
            seen = 0;
         end else if (bus.out_valid) begin
            if (q.size() == 0) begin
               chk("unexpected_out_valid", 64'd1, 64'd0);
            end else begin
               e = q[0];
               if (!seen) begin
                  chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
                  seen = 1;
               end
               chk("hi", {32'd0, hi}, {32'd0, e.hi});
               chk("lo", {32'd0, lo}, {32'd0, e.lo});
               chk("out_data", {32'd0, bus.out_data}, {32'd0, e.data});
               chk("out_wen", {63'd0, bus.out_wen}, {63'd0, e.wen});
               chk("in_ready_in_done", {63'd0, bus.in_ready}, 64'd0);
               if (bus.out_ready) begin
                  void'(q.pop_front());
                  seen = 0;
               end
            end
         end
      end
   end

   // directed stimulus
   initial begin
      int acc;
      int rise_cyc;
      int g;
      bus.in_valid  = 1'b0;
      bus.in_op     = 4'd0;
      bus.in_a      = 32'd0;
      bus.in_b      = 32'd0;
      bus.out_ready = 1'b1;

      // reset state
      repeat (2) @(negedge mul_clk);
      #1;
      chk("rst_hi", {32'd0, hi}, 64'd0);
      chk("rst_lo", {32'd0, lo}, 64'd0);
      chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      @(negedge mul_clk);
      resetn = 1'b1;
      #1;
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // MULT -2*3, MULTU 0xFFFFFFFE*3, MUL 7*-5
      issue(4'd0, 32'hFFFFFFFE, 32'd3, 1'b1, 1, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'd0, 1'b0, 2, acc);
      issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, 1, 32'h00000002, 32'hFFFFFFFA, 32'd0, 1'b0, 2, acc);
      issue(4'd2, 32'd7, 32'hFFFFFFFB, 1'b1, 1, 32'h00000002, 32'hFFFFFFFA, 32'hFFFFFFDD, 1'b1, 2, acc);

      // MTHI/MTLO then accumulate with carry and borrow across LO->HI
      issue(4'd7, 32'h00000001, 32'd0, 1'b0, 1, 32'h00000001, 32'hFFFFFFFA, 32'd0, 1'b0, 1, acc);
      issue(4'd8, 32'hFFFFFFFF, 32'd0, 1'b0, 1, 32'h00000001, 32'hFFFFFFFF, 32'd0, 1'b0, 1, acc);
      issue(4'd4, 32'd1, 32'd1, 1'b0, 1, 32'h00000002, 32'h00000000, 32'd0, 1'b0, 3, acc);
      issue(4'd5, 32'd1, 32'd3, 1'b1, 1, 32'h00000001, 32'hFFFFFFFD, 32'd0, 1'b0, 3, acc);
      issue(4'd3, 32'hFFFFFFFF, 32'd1, 1'b1, 1, 32'h00000001, 32'hFFFFFFFC, 32'd0, 1'b0, 3, acc);
      issue(4'd6, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1, 32'h00000003, 32'hFFFFFFFB, 32'd0, 1'b0, 3, acc);

      // illegal op completes without touching HI/LO
      issue(4'd9, 32'h12345678, 32'h9ABCDEF0, 1'b0, 1, 32'h00000003, 32'hFFFFFFFB, 32'd0, 1'b0, 1, acc);

      // MULT 5*5 with writeback stalled for 4 cycles
      issue(4'd0, 32'd5, 32'd5, 1'b1, 1, 32'h00000000, 32'h00000019, 32'd0, 1'b0, 2, acc);
      bus.out_ready = 1'b0;
      g = 0;
      #1;
      while (!bus.out_valid && g < 20) begin
         @(negedge mul_clk);
         #1;
         g++;
      end
      chk("stall_valid_seen", {63'd0, bus.out_valid}, 64'd1);
      repeat (3) @(negedge mul_clk);
      @(negedge mul_clk);
      bus.out_ready = 1'b1;
      rise_cyc = cyc;
      issue(4'd8, 32'h12345678, 32'd0, 1'b0, 1, 32'h00000000, 32'h12345678, 32'd0, 1'b0, 1, acc);
      chk("accept_after_stall", 64'(acc), 64'(rise_cyc + 1));

      // flush during MUL of MULT 2*2 with HI/LO cleared
      issue(4'd7, 32'd0, 32'd0, 1'b0, 1, 32'h00000000, 32'h12345678, 32'd0, 1'b0, 1, acc);
      issue(4'd8, 32'd0, 32'd0, 1'b0, 1, 32'h00000000, 32'h00000000, 32'd0, 1'b0, 1, acc);
      issue(4'd0, 32'd2, 32'd2, 1'b1, 0, 32'd0, 32'd0, 32'd0, 1'b0, 0, acc);
      flush = 1'b1;
      #1;
      chk("flush_busy_in_mul", {63'd0, busy}, 64'd1);
      @(negedge mul_clk);
      flush = 1'b0;
      #1;
      chk("flush_idle", {63'd0, busy}, 64'd0);
      chk("flush_hi", {32'd0, hi}, 64'd0);
      chk("flush_lo", {32'd0, lo}, 64'd0);
      chk("flush_no_valid", {63'd0, bus.out_valid}, 64'd0);
      repeat (3) @(negedge mul_clk);

      // async reset during ACC of a MADD
      issue(4'd7, 32'd5, 32'd0, 1'b0, 1, 32'h00000005, 32'h00000000, 32'd0, 1'b0, 1, acc);
      issue(4'd3, 32'd1, 32'd1, 1'b1, 0, 32'd0, 32'd0, 32'd0, 1'b0, 0, acc);
      @(negedge mul_clk);
      #1;
      chk("acc_busy", {63'd0, busy}, 64'd1);
      resetn = 1'b0;
      #1;
      chk("arst_hi", {32'd0, hi}, 64'd0);
      chk("arst_lo", {32'd0, lo}, 64'd0);
      chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("arst_out_data", {32'd0, bus.out_data}, 64'd0);
      chk("arst_out_wen", {63'd0, bus.out_wen}, 64'd0);
      chk("arst_busy", {63'd0, busy}, 64'd0);
      @(negedge mul_clk);
      resetn = 1'b1;
      #1;
      chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // MUL after reset
      issue(4'd2, 32'd3, 32'd4, 1'b1, 1, 32'h00000000, 32'h00000000, 32'h0000000C, 1'b1, 2, acc);

      g = 0;
      while (q.size() != 0 && g < 50) begin
         @(negedge mul_clk);
         #2;
         g++;
      end
      chk("scoreboard_drained", 64'(q.size()), 64'd0);
      repeat (2) @(negedge mul_clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
